// File: rtl/deserializer_fifo_if.sv
// deserializer_fifo_if: serial input, word FIFO output and status bundle for deserializer_fifo
interface deserializer_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                       data_in;
    logic                       write_in;
    logic                       ack_in;
    logic                       clear_in;
    logic [WIDTH-1:0]           data_out;
    logic                       data_ready;
    logic                       status_out;
    logic [$clog2(DEPTH+1)-1:0] level_out;
    logic                       overflow_out;
    modport master (
        output data_in, write_in, ack_in, clear_in,
        input  data_out, data_ready, status_out, level_out, overflow_out
    );
    modport slave (
        input  data_in, write_in, ack_in, clear_in,
        output data_out, data_ready, status_out, level_out, overflow_out
    );
endinterface

// File: rtl/deserializer_fifo.sv
// deserializer_fifo: assembles serial bits into WIDTH-bit words and queues them in a DEPTH-entry FIFO
module deserializer_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic clk,
    input logic reset,
    deserializer_fifo_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [CW-1:0]    cnt, idx;
    logic [WIDTH-1:0] shreg, word;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [LW-1:0]    level;
    logic             overflow, full, accept, push, pop;
    always_comb begin
        full = level == LW'(DEPTH);
        accept = bus.write_in && !full && !bus.clear_in;
        push = accept && cnt == CW'(WIDTH - 1);
        pop = bus.ack_in && level != '0;
        idx = MSB_FIRST ? CW'(WIDTH - 1) - cnt : cnt;
        word = shreg;
        word[idx] = bus.data_in;
    end
    // Full is judged on the registered level, so a same-cycle pop does not rescue a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            shreg <= '0;
            overflow <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            level <= '0;
        end else begin
            if (bus.clear_in) begin
                cnt <= '0;
                shreg <= '0;
                overflow <= 1'b0;
            end else if (bus.write_in && full) begin
                overflow <= 1'b1;
            end else if (accept) begin
                cnt <= push ? '0 : cnt + CW'(1);
                shreg <= push ? '0 : word;
            end
            if (push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + PW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr] <= word;
    end
    assign bus.data_out = level != '0 ? mem[rd_ptr] : '0;
    assign bus.data_ready = level != '0;
    assign bus.status_out = full;
    assign bus.level_out = level;
    assign bus.overflow_out = overflow;
endmodule

// File: tb/tb_deserializer_fifo.sv
// tb_deserializer_fifo: LSB-first and MSB-first instances share one serial stream; a monitor scores popped words
module tb_deserializer_fifo;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic d = 1'b0, w = 1'b0, a = 1'b0, c = 1'b0;
    logic saw_full = 1'b0;
    logic [7:0] q0[$], q1[$];
    logic [7:0] m0, m1;
    int total = 0, passed = 0;
    always #5 clk = ~clk;
    deserializer_fifo_if #(.WIDTH(8), .DEPTH(4)) i0 ();
    deserializer_fifo_if #(.WIDTH(8), .DEPTH(4)) i1 ();
    assign i0.data_in = d;
    assign i0.write_in = w;
    assign i0.ack_in = a;
    assign i0.clear_in = c;
    assign i1.data_in = d;
    assign i1.write_in = w;
    assign i1.ack_in = a;
    assign i1.clear_in = c;
    deserializer_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .bus(i0.slave));
    deserializer_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .bus(i1.slave));
    function automatic logic [7:0] rev(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    task automatic cyc(input logic bd, input logic bw, input logic ba, input logic bc);
        d = bd; w = bw; a = ba; c = bc;
        @(posedge clk);
        #1;
        d = 1'b0; w = 1'b0; a = 1'b0; c = 1'b0;
    endtask
    task automatic send_bits(input logic [7:0] x, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) cyc(x[k], 1'b1, 1'b0, 1'b0);
    endtask
    task automatic expect_word(input logic [7:0] x);
        q0.push_back(x);
        q1.push_back(rev(x));
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_data0"}, i0.data_out, 0);
        chk({tag, "_ready0"}, i0.data_ready, 0);
        chk({tag, "_status0"}, i0.status_out, 0);
        chk({tag, "_level0"}, i0.level_out, 0);
        chk({tag, "_ovf0"}, i0.overflow_out, 0);
        chk({tag, "_data1"}, i1.data_out, 0);
        chk({tag, "_ready1"}, i1.data_ready, 0);
        chk({tag, "_level1"}, i1.level_out, 0);
    endtask
    // A word is consumed on the edge after a negedge that sees ack with data_ready.
    always @(negedge clk) begin
        if (!reset && a) begin
            if (i0.data_ready) begin
                total++;
                if (q0.size() == 0) $display("FAIL mon_lsb: got unexpected word %0h expected none", i0.data_out);
                else begin
                    m0 = q0.pop_front();
                    if (i0.data_out === m0) passed++;
                    else $display("FAIL mon_lsb: got %0h expected %0h", i0.data_out, m0);
                end
            end
            if (i1.data_ready) begin
                total++;
                if (q1.size() == 0) $display("FAIL mon_msb: got unexpected word %0h expected none", i1.data_out);
                else begin
                    m1 = q1.pop_front();
                    if (i1.data_out === m1) passed++;
                    else $display("FAIL mon_msb: got %0h expected %0h", i1.data_out, m1);
                end
            end
        end
    end
    initial begin
        logic [7:0] x;
        logic [7:0] t2 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] t3 [3] = '{8'h01, 8'h02, 8'h03};
        reset = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk_zero("reset");
        // Basic word and latency: 1,0,1,0,0,0,0,1 -> 0x85 / 0xA1
        expect_word(8'h85);
        send_bits(8'h85, 0, 6);
        chk("t1_not_ready", i0.data_ready, 0);
        send_bits(8'h85, 7, 7);
        chk("t1_ready", i0.data_ready, 1);
        chk("t1_data_lsb", i0.data_out, 8'h85);
        chk("t1_data_msb", i1.data_out, 8'hA1);
        chk("t1_level", i0.level_out, 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_pop_ready", i0.data_ready, 0);
        chk("t1_pop_data", i0.data_out, 0);
        chk("t1_pop_data_msb", i1.data_out, 0);
        // Fill to full, then overflow with a fifth word
        foreach (t2[i]) begin
            expect_word(t2[i]);
            send_bits(t2[i], 0, 7);
        end
        chk("t2_full", i0.status_out, 1);
        chk("t2_level", i0.level_out, 4);
        chk("t2_no_ovf", i0.overflow_out, 0);
        send_bits(8'h55, 0, 7);
        chk("t2_ovf_lsb", i0.overflow_out, 1);
        chk("t2_ovf_msb", i1.overflow_out, 1);
        chk("t2_level_kept", i0.level_out, 4);
        repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_drained", i0.level_out, 0);
        chk("t2_ovf_sticky", i0.overflow_out, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_clear_ovf", i0.overflow_out, 0);
        // Push and pop together at level 3, then a dropped bit with a pop at level 4
        foreach (t3[i]) begin
            expect_word(t3[i]);
            send_bits(t3[i], 0, 7);
        end
        expect_word(8'h04);
        send_bits(8'h04, 0, 6);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_level3", i0.level_out, 3);
        chk("t3_not_full", i0.status_out, 0);
        expect_word(8'h05);
        send_bits(8'h05, 0, 7);
        chk("t3_level4", i0.level_out, 4);
        chk("t3_full", i0.status_out, 1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t3_drop_level", i0.level_out, 3);
        chk("t3_drop_ovf", i0.overflow_out, 1);
        chk("t3_drop_status", i0.status_out, 0);
        expect_word(8'h06);
        send_bits(8'h06, 0, 7);
        chk("t3_refill", i0.level_out, 4);
        repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_drained", i0.level_out, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        // Partial word discarded by clear; write during clear ignored
        send_bits(8'h1F, 0, 4);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t4_clear_no_ovf", i0.overflow_out, 0);
        chk("t4_clear_level", i0.level_out, 0);
        expect_word(8'hF0);
        send_bits(8'hF0, 0, 7);
        chk("t4_data_lsb", i0.data_out, 8'hF0);
        chk("t4_data_msb", i1.data_out, 8'h0F);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        // Reset mid-word with two words queued
        send_bits(8'hAA, 0, 7);
        send_bits(8'hBB, 0, 7);
        send_bits(8'hCC, 0, 2);
        chk("t5_level2", i0.level_out, 2);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk_zero("midreset");
        expect_word(8'h3C);
        send_bits(8'h3C, 0, 7);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        // Sustained streaming with acks whenever a word is available
        for (int i = 0; i < 16; i++) begin
            x = {4'(i), ~4'(i)};
            expect_word(x);
            for (int k = 0; k < 8; k++) begin
                cyc(x[k], 1'b1, i0.data_ready, 1'b0);
                saw_full = saw_full | i0.status_out | i1.status_out;
            end
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_never_full", saw_full, 0);
        chk("t6_no_ovf", i0.overflow_out, 0);
        chk("t6_level", i0.level_out, 0);
        chk("t6_q_lsb_empty", q0.size(), 0);
        chk("t6_q_msb_empty", q1.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
